mmio_bus_bridge: RTL

Parametrised successor to the top-level data-port address decode. Sits between the CPU data port and N memory-mapped peripherals. Replaces the fixed combinational nibble decode with a table-driven region map, a per-slave request/acknowledge handshake (variable wait states), a timeout watchdog and a bus-error response with error status. Slaves range from single-cycle RAM to slow peripherals such as a joypad bridge or an LCD unit.

---
 rtl/bus_pkg.sv | 24 ++
 rtl/region_decoder.sv | 25 ++
 rtl/mmio_bus_bridge.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the data-side MMIO bridge: FSM states, default region map
// and the named slave slots used by the SoC integration.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERROR  = 2'd2
    } bus_state_t;

    // One nibble per 256 MB region, entry 0 in the least significant nibble.
    localparam logic [63:0] DEFAULT_REGION_MAP = 64'h9988_7766_5432_1100;

    localparam int unsigned SLV_RAM    = 0;
    localparam int unsigned SLV_RNG    = 1;
    localparam int unsigned SLV_VTATTR = 2;
    localparam int unsigned SLV_VTDATA = 3;
    localparam int unsigned SLV_JOYPAD = 4;
    localparam int unsigned SLV_VPAL   = 5;
    localparam int unsigned SLV_VCTRL  = 6;
    localparam int unsigned SLV_LCD    = 7;
    localparam int unsigned SLV_AUDIO  = 9;

endpackage

// File: rtl/region_decoder.sv
// Combinational table lookup: top address bits select a map entry naming the slave.
// Shared between the data-side bridge and the instruction fetch path.
module region_decoder
    import bus_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 10,
    parameter int unsigned SEL_BITS   = 4,
    parameter int unsigned IDX_W      = 4,
    parameter logic [(2**SEL_BITS)*IDX_W-1:0] REGION_MAP = DEFAULT_REGION_MAP
) (
    input  logic [31:0]      addr,
    output logic [IDX_W-1:0] slave_idx,
    output logic             mapped
);

    logic [SEL_BITS-1:0] sel;
    logic                unused_low;

    assign sel        = addr[31 -: SEL_BITS];
    assign unused_low = ^addr[31-SEL_BITS:0];

    assign slave_idx = REGION_MAP[sel*IDX_W +: IDX_W];
    assign mapped    = (32'(slave_idx) < NUM_SLAVES);

endmodule

// File: rtl/mmio_bus_bridge.sv
// CPU data port to memory-mapped slave bridge: table-driven decode, req/ack handshake
// with wait states, ack timeout watchdog and bus-error reporting.
module mmio_bus_bridge
    import bus_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 10,
    parameter int unsigned SEL_BITS   = 4,
    parameter int unsigned IDX_W      = 4,
    parameter logic [(2**SEL_BITS)*IDX_W-1:0] REGION_MAP = DEFAULT_REGION_MAP,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       host_valid,
    output logic                       host_ready,
    input  logic [31:0]                host_addr,
    input  logic [31:0]                host_wdata,
    input  logic [3:0]                 host_wstrb,
    output logic                       host_resp_valid,
    output logic [31:0]                host_rdata,
    output logic                       host_err,
    output logic [NUM_SLAVES-1:0]      slv_req,
    output logic [31:0]                slv_addr,
    output logic [31:0]                slv_wdata,
    output logic [3:0]                 slv_wstrb,
    input  logic [NUM_SLAVES-1:0]      slv_ack,
    input  logic [32*NUM_SLAVES-1:0]   slv_rdata,
    output logic [7:0]                 err_count,
    output logic [31:0]                err_addr
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    bus_state_t       state, state_next;
    logic [IDX_W-1:0] dec_idx;
    logic             dec_mapped;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt;
    logic             sel_ack;
    logic             timed_out;

    region_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_BITS   (SEL_BITS),
        .IDX_W      (IDX_W),
        .REGION_MAP (REGION_MAP)
    ) u_decoder (
        .addr      (host_addr),
        .slave_idx (dec_idx),
        .mapped    (dec_mapped)
    );

    assign sel_ack    = slv_ack[idx_q];
    // Fires in the last permitted wait cycle so slv_req is high exactly TIMEOUT cycles.
    assign timed_out  = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    assign host_ready = (state == IDLE);

    // Request is decoded from state so an asynchronous reset drops it immediately.
    always_comb begin
        slv_req = '0;
        if (state == ACCESS) begin
            slv_req[idx_q] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (host_valid) begin
                    state_next = dec_mapped ? ACCESS : ERROR;
                end
            end
            ACCESS: begin
                if (sel_ack) begin
                    state_next = IDLE;
                end else if (timed_out) begin
                    state_next = ERROR;
                end
            end
            ERROR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q           <= '0;
            cnt             <= '0;
            slv_addr        <= '0;
            slv_wdata       <= '0;
            slv_wstrb       <= '0;
            host_resp_valid <= 1'b0;
            host_err        <= 1'b0;
            host_rdata      <= '0;
            err_count       <= '0;
            err_addr        <= '0;
        end else begin
            host_resp_valid <= 1'b0;
            host_err        <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (host_valid) begin
                        slv_addr  <= host_addr;
                        slv_wdata <= host_wdata;
                        slv_wstrb <= host_wstrb;
                        idx_q     <= dec_idx;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (sel_ack) begin
                        host_resp_valid <= 1'b1;
                        host_rdata      <= (slv_wstrb == 4'b0000) ? slv_rdata[idx_q*32 +: 32] : '0;
                    end
                end
                ERROR: begin
                    host_resp_valid <= 1'b1;
                    host_err        <= 1'b1;
                    host_rdata      <= '0;
                    err_addr        <= slv_addr;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule
